fir_mac_sched: RTL

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_mac_unit.sv | 18 +
 rtl/fir_mac_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR filter.
// Output clamping via to_out() is enabled by defining FIR_SAT_EN.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int OW = 18;
  localparam int AW = 22;

  localparam logic signed [AW-1:0] SAT_MAX = 22'sd131071;
  localparam logic signed [AW-1:0] SAT_MIN = -22'sd131072;

  function automatic logic [OW-1:0] to_out(
    input logic signed [AW-1:0] acc
  );
`ifdef FIR_SAT_EN
    if (acc > SAT_MAX)
      return SAT_MAX[OW-1:0];
    else if (acc < SAT_MIN)
      return SAT_MIN[OW-1:0];
    else
      return acc[OW-1:0];
`else
    return acc[OW-1:0];
`endif
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Q15 multiply-and-truncate: h*x, keep bits [30:15], sign-extend to 22.
// Ports: h, x (signed Q1.15 in), p (signed 22-bit product term out).
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic signed [DW-1:0] h,
  input  logic signed [DW-1:0] x,
  output logic signed [AW-1:0] p
);

  logic signed [PW-1:0] prod;
  logic unused_bits;

  assign prod = h * x;
  assign p = {{(AW-16){prod[30]}}, prod[30:15]};
  assign unused_bits = ^{prod[31], prod[14:0]};

endmodule

// File: rtl/fir_mac_sched.sv
// NTAPS-tap FIR, one shared multiplier, one tap per cycle (IDLE/MAC/DONE).
// Ports: clk, i_rst (sync, active-low), i_x/i_valid/o_ready sample in,
// o_y/o_valid/i_ready result out, i_coef_we/i_coef_addr/i_coef_data
// coefficient write port, o_coef_err reject pulse.
// Define FIR_SAT_EN to saturate o_y instead of wrapping.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int NTAPS = 4
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [15:0] i_x,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [17:0] o_y,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_coef_we,
  input  logic [3:0]  i_coef_addr,
  input  logic [15:0] i_coef_data,
  output logic        o_coef_err
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int KL = NTAPS - 1;
  localparam logic [IW-1:0] KLAST = KL[IW-1:0];
  localparam logic [IW:0] NTW = NTAPS[IW:0];
  localparam logic [4:0] NT5 = NTAPS[4:0];

  state_t state, nxt;

  logic [IW-1:0] k;
  logic [IW-1:0] head;
  logic [IW-1:0] idx;
  logic [IW:0] idx_w;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] prod;
  logic signed [DW-1:0] dl [NTAPS];
  logic signed [DW-1:0] coef [NTAPS];
  logic addr_ok;
  logic coef_err;
  logic unused_idx;

  // x[n-k] lives at (head-k) mod NTAPS
  assign idx_w = (head >= k)
    ? {1'b0, head} - {1'b0, k}
    : {1'b0, head} + NTW - {1'b0, k};
  assign idx = idx_w[IW-1:0];
  assign unused_idx = idx_w[IW];

  assign addr_ok = ({1'b0, i_coef_addr} < NT5);

  fir_mac_unit u_mac (
    .h (coef[k]),
    .x (dl[idx]),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!i_rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (i_valid) nxt = MAC;
      MAC:  if (k == KLAST) nxt = DONE;
      DONE: if (i_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // Coefficient write lands on the same edge a sample is accepted,
  // so the first MAC cycle already reads the new value.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      acc <= '0;
      k <= '0;
      head <= '0;
      coef_err <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dl[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      coef_err <= i_coef_we && ((state != IDLE) || !addr_ok);
      if (i_coef_we && (state == IDLE) && addr_ok)
        coef[i_coef_addr[IW-1:0]] <= i_coef_data;
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            dl[head] <= i_x;
            acc <= '0;
            k <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          if (k == KLAST) begin
            k <= '0;
            head <= (head == KLAST) ? '0 : head + 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign o_y = to_out(acc);
  assign o_coef_err = coef_err;

endmodule
